dyt_ex_mem_latch: RTL and testbench
===================================

Name: dyt_ex_mem_latch

Overview:
- Execute-to-memory pipeline boundary, directly downstream of the ALU.
- Captures the ALU result plus execute-stage control into a 2-entry skid buffer with a valid/ready handshake toward the MEM stage.
- Resolves conditional branches and jumps from the ALU flags and emits a one-cycle redirect to fetch.
- Supports a synchronous pipeline flush.

Parameters:
WORD_W, 32, datapath width (result, pc, store data)
REG_AW, 5, register index width

Ports:
clk  in  1  core clock
rst  in  1  synchronous active-high reset
flush  in  1  drop all held and incoming entries this cycle
ex_valid  in  1  execute stage presents an instruction
ex_ready  out  1  latch can accept (registered, = skid entry empty)
alu_port_out  in  WORD_W  ALU result
alu_zero  in  1  ALU zero flag
ex_pc  in  WORD_W  instruction pc
ex_br_type  in  3  br_type_t: NONE, BEQ, BNE, BLT, BGE, BLTU, BGEU, JUMP
ex_br_target  in  WORD_W  precomputed branch/jump target
ex_rd  in  REG_AW  destination register
ex_reg_wen  in  1  writes rd
ex_mem_ren  in  1  load
ex_mem_wen  in  1  store
ex_store_data  in  WORD_W  store data
mem_valid  out  1  entry presented to MEM
mem_ready  in  1  MEM accepts
mem_result  out  WORD_W  result, or pc+4 for JUMP
mem_rd, mem_reg_wen, mem_mem_ren, mem_mem_wen, mem_store_data  out  as inputs  forwarded control/data
redirect_valid  out  1  one-cycle pulse, branch/jump taken
redirect_pc  out  WORD_W  target for fetch

Behaviour:
- Clock, reset: one clock, clk; reset rst is synchronous and active-high.
- Reset: all state to EMPTY. mem_valid=0, ex_ready=1, redirect_valid=0, redirect_pc=0, all mem_* data outputs=0.
- Accept: ex_valid & ex_ready & ~flush. Release: mem_valid & mem_ready.
- States:
  - EMPTY (no entries)
  - MAIN (output reg holds an entry, skid empty)
  - FULL (both hold entries)
- Transitions:
  - EMPTY, accept -> MAIN.
  - MAIN: accept & release -> MAIN (new entry loads output reg); accept & ~release -> FULL (new entry goes to skid); release only -> EMPTY.
  - FULL: release -> MAIN (skid moves to output reg); no accept is possible since ex_ready=0.
- Latency: an accepted entry appears on mem_* the next cycle when the buffer was EMPTY or is draining. Outputs come straight from the output register, with no combinational path from mem_ready to ex_ready.
- Ordering: strict FIFO. Data is held stable while mem_valid & ~mem_ready.
- Branch resolution at accept, per br_type:
  - BEQ: taken=alu_zero. BNE: taken=~alu_zero.
  - BLT/BLTU: taken=alu_port_out[0] (ALU performed SLT/SLTU).
  - BGE/BGEU: taken=~alu_port_out[0].
  - JUMP: taken=1.
  - NONE: taken=0.
- Redirect timing: when taken, redirect_valid=1 and redirect_pc=ex_br_target on the cycle after accept, for exactly one cycle, independent of MEM stalls. redirect_pc holds its last value when not valid.
- JUMP writes pc+4 (mod 2^WORD_W) to mem_result. Branches force mem_reg_wen=0.
- Flush:
  - Clears both entries, so next cycle mem_valid=0, ex_ready=1.
  - Flush overrides a same-cycle accept: the incoming entry is dropped and no redirect is generated for it.
  - A redirect already registered (pulse in this cycle) still completes.
  - Flush and release in the same cycle: the release completes on the MEM side; the latch still empties.
- Reset mid-operation: behaves like flush and also clears redirect_valid.
- Unknown br_type encodings behave as NONE.

Decomposition:
- common_types gains br_type_t (3-bit enum) and exmem_t (packed struct of result, rd, reg_wen, mem_ren, mem_wen, store_data).
- Sub-module dyt_skid_buf: generic 2-entry valid/ready buffer parameterised on payload width, carrying exmem_t. The top block holds branch resolution, the redirect register, and JUMP result selection.

Test Plan:
- Streaming with mem_ready=1: 4 back-to-back NONE ops with results 0x1,0x2,0x3,0x4 -> each appears on mem_result 1 cycle after accept; ex_ready stays 1; mem_valid high for 4 consecutive cycles.
- Backpressure: mem_ready=0 while 3 ops are offered -> 2 accepted, then ex_ready=0. Raise mem_ready -> outputs drain in order 0xA,0xB; third op is accepted once ex_ready returns to 1.
- Branches:
  - BEQ with alu_zero=1, target 0x100 -> redirect_valid pulses 1 cycle with redirect_pc=0x100, mem_reg_wen=0.
  - BNE with alu_zero=1 -> no redirect.
  - BLTU with alu_port_out=1, target 0x80 -> redirect to 0x80.
- JUMP at ex_pc=0xFFFFFFFC, rd=1 -> mem_result=0x00000000 (wrap), mem_reg_wen=1, redirect pulse issued.
- Flush in FULL state with a simultaneous ex_valid -> next cycle mem_valid=0, ex_ready=1; the dropped op never reaches the output and no redirect is generated for it.
- rst asserted in FULL state with a redirect pending -> next cycle all outputs at their reset values, redirect_valid=0.

Source files
------------

// File: rtl/dyt_ex_mem_latch_pkg.sv
// Shared types for the execute-to-memory boundary: branch encodings, the
// EX/MEM payload record and the skid buffer occupancy states.
package dyt_ex_mem_latch_pkg;

    localparam int EXM_WORD_W = 32;
    localparam int EXM_REG_AW = 5;

    typedef enum logic [2:0] {
        BR_NONE = 3'd0,
        BR_BEQ  = 3'd1,
        BR_BNE  = 3'd2,
        BR_BLT  = 3'd3,
        BR_BGE  = 3'd4,
        BR_BLTU = 3'd5,
        BR_BGEU = 3'd6,
        BR_JUMP = 3'd7
    } br_type_t;

    typedef struct packed {
        logic [EXM_WORD_W-1:0] result;
        logic [EXM_REG_AW-1:0] rd;
        logic                  reg_wen;
        logic                  mem_ren;
        logic                  mem_wen;
        logic [EXM_WORD_W-1:0] store_data;
    } exmem_t;

    typedef enum logic [1:0] {
        SB_EMPTY = 2'd0,
        SB_MAIN  = 2'd1,
        SB_FULL  = 2'd2
    } skid_state_t;

    // Conditional branches never write a register; JUMP is the link case.
    function automatic logic is_cond_branch(input br_type_t br);
        return (br == BR_BEQ) || (br == BR_BNE) || (br == BR_BLT) ||
               (br == BR_BGE) || (br == BR_BLTU) || (br == BR_BGEU);
    endfunction

endpackage

// File: rtl/dyt_ex_mem_latch_skid.sv
// Generic 2-entry valid/ready skid buffer; both in_ready and out_valid are
// registered so no combinational path runs from out_ready to in_ready.
module dyt_skid_buf
    import dyt_ex_mem_latch_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    skid_state_t  state;
    logic [W-1:0] skid_data;
    logic         accept;
    logic         release_out;

    assign accept      = in_valid & in_ready & ~flush;
    assign release_out = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= SB_EMPTY;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            skid_data <= '0;
        end else if (flush) begin
            // A same-cycle release still completes downstream; the buffer just empties.
            state     <= SB_EMPTY;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                SB_EMPTY: begin
                    if (accept) begin
                        out_data  <= in_data;
                        out_valid <= 1'b1;
                        state     <= SB_MAIN;
                    end
                end
                SB_MAIN: begin
                    if (accept && release_out) begin
                        out_data <= in_data;
                    end else if (accept) begin
                        skid_data <= in_data;
                        in_ready  <= 1'b0;
                        state     <= SB_FULL;
                    end else if (release_out) begin
                        out_valid <= 1'b0;
                        state     <= SB_EMPTY;
                    end
                end
                SB_FULL: begin
                    if (release_out) begin
                        out_data <= skid_data;
                        in_ready <= 1'b1;
                        state    <= SB_MAIN;
                    end
                end
                default: begin
                    state     <= SB_EMPTY;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/dyt_ex_mem_latch.sv
// EX/MEM pipeline boundary: resolves branches at accept, emits a one-cycle
// fetch redirect, and queues the ALU result through a 2-entry skid buffer.
module dyt_ex_mem_latch
    import dyt_ex_mem_latch_pkg::*;
#(
    parameter int WORD_W = EXM_WORD_W,
    parameter int REG_AW = EXM_REG_AW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [WORD_W-1:0] alu_port_out,
    input  logic              alu_zero,
    input  logic [WORD_W-1:0] ex_pc,
    input  logic [2:0]        ex_br_type,
    input  logic [WORD_W-1:0] ex_br_target,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_reg_wen,
    input  logic              ex_mem_ren,
    input  logic              ex_mem_wen,
    input  logic [WORD_W-1:0] ex_store_data,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [WORD_W-1:0] mem_result,
    output logic [REG_AW-1:0] mem_rd,
    output logic              mem_reg_wen,
    output logic              mem_mem_ren,
    output logic              mem_mem_wen,
    output logic [WORD_W-1:0] mem_store_data,
    output logic              redirect_valid,
    output logic [WORD_W-1:0] redirect_pc
);

    br_type_t br;
    logic     taken;
    logic     accept;
    exmem_t   in_entry;
    exmem_t   out_entry;

    assign br     = br_type_t'(ex_br_type);
    assign accept = ex_valid & ex_ready & ~flush;

    always_comb begin
        taken = 1'b0;
        case (br)
            BR_BEQ:  taken = alu_zero;
            BR_BNE:  taken = ~alu_zero;
            BR_BLT,
            BR_BLTU: taken = alu_port_out[0];
            BR_BGE,
            BR_BGEU: taken = ~alu_port_out[0];
            BR_JUMP: taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        in_entry            = '0;
        in_entry.result     = (br == BR_JUMP) ? (ex_pc + WORD_W'(4)) : alu_port_out;
        in_entry.rd         = ex_rd;
        in_entry.reg_wen    = ex_reg_wen & ~is_cond_branch(br);
        in_entry.mem_ren    = ex_mem_ren;
        in_entry.mem_wen    = ex_mem_wen;
        in_entry.store_data = ex_store_data;
    end

    // Redirect fires the cycle after accept regardless of MEM backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
        end else begin
            redirect_valid <= accept & taken;
            if (accept && taken) begin
                redirect_pc <= ex_br_target;
            end
        end
    end

    dyt_skid_buf #(
        .W($bits(exmem_t))
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (ex_valid),
        .in_ready (ex_ready),
        .in_data  (in_entry),
        .out_valid(mem_valid),
        .out_ready(mem_ready),
        .out_data (out_entry)
    );

    assign mem_result     = out_entry.result;
    assign mem_rd         = out_entry.rd;
    assign mem_reg_wen    = out_entry.reg_wen;
    assign mem_mem_ren    = out_entry.mem_ren;
    assign mem_mem_wen    = out_entry.mem_wen;
    assign mem_store_data = out_entry.store_data;

endmodule

// File: tb/tb_dyt_ex_mem_latch.sv
// Directed bench for dyt_ex_mem_latch: streaming, backpressure, branch
// resolution, JUMP link wrap, flush and reset in the full state.
module tb_dyt_ex_mem_latch;

    logic        clk = 1'b0;
    logic        rst, flush, ex_valid, ex_ready, alu_zero;
    logic [31:0] alu_port_out, ex_pc, ex_br_target, ex_store_data;
    logic [2:0]  ex_br_type;
    logic [4:0]  ex_rd, mem_rd;
    logic        ex_reg_wen, ex_mem_ren, ex_mem_wen;
    logic        mem_valid, mem_ready, mem_reg_wen, mem_mem_ren, mem_mem_wen;
    logic [31:0] mem_result, mem_store_data, redirect_pc;
    logic        redirect_valid;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dyt_ex_mem_latch dut (
        .clk(clk), .rst(rst), .flush(flush),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .alu_port_out(alu_port_out), .alu_zero(alu_zero),
        .ex_pc(ex_pc), .ex_br_type(ex_br_type), .ex_br_target(ex_br_target),
        .ex_rd(ex_rd), .ex_reg_wen(ex_reg_wen), .ex_mem_ren(ex_mem_ren),
        .ex_mem_wen(ex_mem_wen), .ex_store_data(ex_store_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_result(mem_result),
        .mem_rd(mem_rd), .mem_reg_wen(mem_reg_wen), .mem_mem_ren(mem_mem_ren),
        .mem_mem_wen(mem_mem_wen), .mem_store_data(mem_store_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic [2:0] br, input logic [31:0] alu, input logic zero,
                      input logic [31:0] pc, input logic [31:0] tgt, input logic [4:0] rd,
                      input logic wen, input logic ren, input logic mwen, input logic [31:0] sd);
        ex_valid      = 1'b1;
        ex_br_type    = br;
        alu_port_out  = alu;
        alu_zero      = zero;
        ex_pc         = pc;
        ex_br_target  = tgt;
        ex_rd         = rd;
        ex_reg_wen    = wen;
        ex_mem_ren    = ren;
        ex_mem_wen    = mwen;
        ex_store_data = sd;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; mem_ready = 1'b1;
        op(3'd0, 32'h0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0);
        ex_valid = 1'b0;
        tick(); tick();
        chk("rst_mem_valid", 32'(mem_valid), 32'd0);
        chk("rst_ex_ready", 32'(ex_ready), 32'd1);
        chk("rst_redir_valid", 32'(redirect_valid), 32'd0);
        chk("rst_redir_pc", redirect_pc, 32'h0);
        chk("rst_result", mem_result, 32'h0);
        chk("rst_store_data", mem_store_data, 32'h0);
        rst = 1'b0;
        tick();

        // Streaming, mem_ready held high
        for (int i = 1; i <= 4; i++) begin
            op(3'd0, 32'(i), 1'b0, 32'h10 * i, 32'h0, 5'(i), 1'b1, 1'b0, 1'(i % 2), 32'h1000 + i);
            tick();
            chk("strm_valid", 32'(mem_valid), 32'd1);
            chk("strm_result", mem_result, 32'(i));
            chk("strm_rd", 32'(mem_rd), 32'(i));
            chk("strm_ex_ready", 32'(ex_ready), 32'd1);
            chk("strm_mem_wen", 32'(mem_mem_wen), 32'(i % 2));
            chk("strm_sd", mem_store_data, 32'h1000 + i);
        end
        ex_valid = 1'b0;
        tick();
        chk("strm_drained", 32'(mem_valid), 32'd0);

        // Backpressure: A, B accepted, C held off until a slot frees
        mem_ready = 1'b0;
        op(3'd0, 32'hA, 1'b0, 32'h0, 32'h0, 5'd2, 1'b1, 1'b1, 1'b0, 32'h0);
        tick();
        chk("bp_a_out", mem_result, 32'hA);
        chk("bp_ready1", 32'(ex_ready), 32'd1);
        op(3'd0, 32'hB, 1'b0, 32'h0, 32'h0, 5'd3, 1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        chk("bp_full_ready", 32'(ex_ready), 32'd0);
        chk("bp_a_held", mem_result, 32'hA);
        chk("bp_a_ren", 32'(mem_mem_ren), 32'd1);
        op(3'd0, 32'hC, 1'b0, 32'h0, 32'h0, 5'd4, 1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        chk("bp_still_full", 32'(ex_ready), 32'd0);
        chk("bp_a_held2", mem_result, 32'hA);
        mem_ready = 1'b1;
        tick();
        chk("bp_b_out", mem_result, 32'hB);
        chk("bp_ready_back", 32'(ex_ready), 32'd1);
        tick();
        chk("bp_c_out", mem_result, 32'hC);
        chk("bp_c_valid", 32'(mem_valid), 32'd1);
        ex_valid = 1'b0;
        tick();
        chk("bp_empty", 32'(mem_valid), 32'd0);

        // BEQ taken: redirect and forced reg_wen=0
        op(3'd1, 32'h0, 1'b1, 32'h20, 32'h100, 5'd7, 1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        chk("beq_redir_v", 32'(redirect_valid), 32'd1);
        chk("beq_redir_pc", redirect_pc, 32'h100);
        chk("beq_reg_wen", 32'(mem_reg_wen), 32'd0);
        ex_valid = 1'b0;
        tick();
        chk("beq_pulse_end", 32'(redirect_valid), 32'd0);
        chk("beq_pc_hold", redirect_pc, 32'h100);

        // BNE with zero set: not taken
        op(3'd2, 32'h0, 1'b1, 32'h24, 32'h200, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        chk("bne_no_redir", 32'(redirect_valid), 32'd0);
        chk("bne_pc_hold", redirect_pc, 32'h100);
        chk("bne_valid", 32'(mem_valid), 32'd1);

        // BLTU with SLTU result 1: taken
        op(3'd5, 32'h1, 1'b0, 32'h28, 32'h80, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        chk("bltu_redir_v", 32'(redirect_valid), 32'd1);
        chk("bltu_redir_pc", redirect_pc, 32'h80);

        // JUMP link wraps to 0
        op(3'd7, 32'h1234, 1'b0, 32'hFFFF_FFFC, 32'h40, 5'd1, 1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        chk("jump_result", mem_result, 32'h0);
        chk("jump_reg_wen", 32'(mem_reg_wen), 32'd1);
        chk("jump_rd", 32'(mem_rd), 32'd1);
        chk("jump_redir_v", 32'(redirect_valid), 32'd1);
        chk("jump_redir_pc", redirect_pc, 32'h40);

        // Flush while FULL with a taken JUMP offered
        mem_ready = 1'b0;
        op(3'd0, 32'hD, 1'b0, 32'h30, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        chk("fl_full", 32'(ex_ready), 32'd0);
        flush = 1'b1;
        op(3'd7, 32'hE, 1'b0, 32'h34, 32'h300, 5'd6, 1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        chk("fl_mem_valid", 32'(mem_valid), 32'd0);
        chk("fl_ex_ready", 32'(ex_ready), 32'd1);
        chk("fl_no_redir", 32'(redirect_valid), 32'd0);
        flush = 1'b0;
        ex_valid = 1'b0;
        mem_ready = 1'b1;
        tick();
        chk("fl_stays_empty", 32'(mem_valid), 32'd0);
        chk("fl_pc_hold", redirect_pc, 32'h40);

        // Reset while FULL with a redirect pulse in flight
        mem_ready = 1'b0;
        op(3'd0, 32'h55, 1'b0, 32'h40, 32'h0, 5'd8, 1'b1, 1'b1, 1'b1, 32'hABCD);
        tick();
        op(3'd7, 32'h0, 1'b0, 32'h44, 32'h500, 5'd9, 1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        chk("rs_full", 32'(ex_ready), 32'd0);
        chk("rs_pending", 32'(redirect_valid), 32'd1);
        rst = 1'b1;
        ex_valid = 1'b0;
        tick();
        chk("rs_mem_valid", 32'(mem_valid), 32'd0);
        chk("rs_ex_ready", 32'(ex_ready), 32'd1);
        chk("rs_redir_v", 32'(redirect_valid), 32'd0);
        chk("rs_redir_pc", redirect_pc, 32'h0);
        chk("rs_result", mem_result, 32'h0);
        chk("rs_rd", 32'(mem_rd), 32'd0);
        chk("rs_flags", {29'd0, mem_reg_wen, mem_mem_ren, mem_mem_wen}, 32'd0);
        chk("rs_sd", mem_store_data, 32'h0);
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
